booth_pp_stream: RTL and testbench
==================================

// Module: booth_pp_stream
// PURPOSE
//  Parametrised radix-4 Booth partial-product generator for the Wallace-tree multiplier path.
//  Accepts one operand pair (signed or unsigned) per transaction and emits all Booth partial products.
//  Each product is pre-shifted and sign-extended to 2*WIDTH bits, streamed PP_PER_BEAT per beat to the compressor/accumulator.
//  Holds its output under backpressure. Sum of all emitted products mod 2^(2*WIDTH) equals A*B.
// PARAMETERS
//  WIDTH        32  operand width; must be even and >= 4
//  PP_PER_BEAT  1   partial products per output beat; 1..NUM_PP
//  (derived) NUM_PP = WIDTH/2+1; NUM_BEATS = ceil(NUM_PP/PP_PER_BEAT)
// PORTS
//  mul_clk    in   1                      clock; all state on rising edge
//  mul_rst    in   1                      synchronous, active-high reset
//  in_valid   in   1                      operand pair valid
//  in_ready   out  1                      block can accept operands
//  in_a       in   WIDTH                  multiplicand
//  in_b       in   WIDTH                  multiplier (Booth-recoded)
//  in_signed  in   1                      1: both operands two's complement; 0: both unsigned
//  pp_valid   out  1                      output beat valid
//  pp_ready   in   1                      downstream accepts beat
//  pp_data    out  PP_PER_BEAT*2*WIDTH    slot k = partial product pp_index*PP_PER_BEAT+k
//  pp_index   out  $clog2(NUM_BEATS+1)    beat number, 0..NUM_BEATS-1
//  pp_last    out  1                      final beat of transaction
// BEHAVIOUR
//  - Reset (mul_rst high at edge): state IDLE, pp_valid=0, pp_data=0, pp_index=0, pp_last=0.
//    in_ready=0 while mul_rst high.
//  - FSM IDLE/GEN. in_ready = (state==IDLE) && !mul_rst.
//  - IDLE: on in_valid&&in_ready, register in_a, in_b, in_signed and go to GEN.
//    Beat 0 is driven registered on pp_data with pp_valid=1 the next cycle (latency 1).
//  - GEN: a beat advances only on pp_valid&&pp_ready. Next beat appears the following cycle (1 beat/cycle with pp_ready held high).
//  - pp_valid=0: pp_data, pp_index and pp_last hold.
//  - pp_valid=1 and pp_ready=0: pp_data, pp_index and pp_last hold stable.
//  - pp_last=1 exactly on beat NUM_BEATS-1. Its handshake returns the FSM to IDLE and drops pp_valid the next cycle.
//    in_ready rises in that same next cycle; no overlap of transactions.
//  - in_valid during GEN is ignored (in_ready=0). Operands are not re-sampled mid-transaction.
//  - Operand extension:
//    B' = {e,e,in_b,0} with e = in_signed ? in_b[WIDTH-1] : 0.
//    A' = {f,in_a} with f = in_signed ? in_a[WIDTH-1] : 0.
//  - Group i (0..NUM_PP-1) reads B' bits [2i+2:2i] = {b2i+1, b2i, b2i-1}.
//    Digit d = -2*b2i+1 + b2i + b2i-1, in {-2,-1,0,+1,+2}.
//  - PP_i = sext_2W(d*A') << 2i, truncated to 2*WIDTH bits, two's complement.
//    Negation is exact (~x+1); no separate correction row.
//  - Signed mode: group NUM_PP-1 always yields d=0; it is still emitted, as zero.
//  - Padding slots with index >= NUM_PP in the last beat are driven 0.
//  - Reset mid-GEN: transaction abandoned. pp_valid=0 in the cycle after the reset edge; no further beats.
// STRUCTURE
//  - booth_pkg holds:
//    booth_digit_t enum {ZERO, POS1, POS2, NEG1, NEG2};
//    function booth_encode(3b) -> booth_digit_t;
//    function num_pp(width).
//  - Sub-module booth_pp_slice (combinational): inputs A' (WIDTH+1 bits), 3 recode bits, group index.
//    Output: one 2*WIDTH partial product.
//  - Instantiate PP_PER_BEAT slices, muxed by beat counter.
//  - Top level holds the FSM, operand registers, beat counter and output register.
// TESTING (check: sum of all slots mod 2^64 == A*B every case)
//  1. WIDTH=32, PPB=1, unsigned A=3, B=5 -> 17 beats; PP0=3, PP1=12, others 0; pp_last on index 16.
//  2. Signed A=0xFFFFFFF9 (-7), B=0xFFFFFFFF (-1) -> PP0=0x0000000000000007, PP1..16=0; sum=7.
//  3. Unsigned A=B=0xFFFFFFFF -> PP16=0xFFFFFFFF00000000; sum=0xFFFFFFFE00000001.
//  4. Case 1 with pp_ready low 5 cycles at beat 3 -> pp_data/pp_index stable, pp_valid held; no beat lost or duplicated.
//  5. mul_rst pulsed at beat 8, in_valid held high during GEN:
//     -> in_ready=0 in GEN; pp_valid=0 the cycle after the reset edge; clean new transaction afterwards.
//  6. PPB=4, signed A=0x80000000, B=0x80000000 -> 5 beats; beat 4 slots 1..3 zero; sum=0x4000000000000000.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth
// partial-product path (digit encoding, FSM states, sizing).
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  typedef enum logic {
    S_IDLE,
    S_GEN
  } booth_state_t;

  // {b2i+1, b2i, b2i-1} -> digit in {-2..+2}
  function automatic booth_digit_t booth_encode(
    input logic [2:0] i_bits
  );
    booth_digit_t w_d;
    unique case (i_bits)
      3'b001,
      3'b010:  w_d = POS1;
      3'b011:  w_d = POS2;
      3'b100:  w_d = NEG2;
      3'b101,
      3'b110:  w_d = NEG1;
      default: w_d = ZERO;
    endcase
    return w_d;
  endfunction

  function automatic int num_pp(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_pp_slice.sv
// booth_pp_slice: one radix-4 Booth partial product, sign-extended
// to 2*WIDTH bits and pre-shifted by 2*group.
module booth_pp_slice
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GW    = 5
) (
  input  logic [WIDTH:0]       i_a_ext,
  input  logic [2:0]           i_bits,
  input  logic [GW-1:0]        i_grp,
  output logic [2*WIDTH-1:0]   o_pp
);

  localparam int DW = 2 * WIDTH;

  booth_digit_t  w_digit;
  logic [DW-1:0] w_a_sx;
  logic [DW-1:0] w_mag;
  logic          w_neg;
  logic [DW-1:0] w_term;

  assign w_digit = booth_encode(i_bits);
  assign w_a_sx  = {{(WIDTH-1){i_a_ext[WIDTH]}}, i_a_ext};

  // Magnitude (|d|*A') and sign of the selected digit
  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    unique case (w_digit)
      POS1: w_mag = w_a_sx;
      POS2: w_mag = w_a_sx << 1;
      NEG1: begin
        w_mag = w_a_sx;
        w_neg = 1'b1;
      end
      NEG2: begin
        w_mag = w_a_sx << 1;
        w_neg = 1'b1;
      end
      default: w_mag = '0;
    endcase
  end

  // Exact two's-complement negation, so no correction row is needed
  assign w_term = w_neg
    ? (~w_mag + {{(DW-1){1'b0}}, 1'b1})
    : w_mag;

  assign o_pp = w_term << {i_grp, 1'b0};

endmodule

// File: rtl/booth_pp_stream.sv
// booth_pp_stream: accepts one operand pair and streams all radix-4
// Booth partial products, PP_PER_BEAT per beat, with backpressure.
module booth_pp_stream
  import booth_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int PP_PER_BEAT = 1,
  localparam int NUM_PP      = num_pp(WIDTH),
  localparam int NUM_BEATS   =
    (NUM_PP + PP_PER_BEAT - 1) / PP_PER_BEAT,
  localparam int IW          = $clog2(NUM_BEATS + 1)
) (
  input  logic                           mul_clk,
  input  logic                           mul_rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic                           in_signed,
  output logic                           pp_valid,
  input  logic                           pp_ready,
  output logic [PP_PER_BEAT*2*WIDTH-1:0] pp_data,
  output logic [IW-1:0]                  pp_index,
  output logic                           pp_last
);

  localparam int DW = 2 * WIDTH;
  localparam int GW = $clog2(NUM_BEATS * PP_PER_BEAT + 1);
  localparam logic [IW-1:0] LB = IW'(NUM_BEATS - 1);

  booth_state_t r_state;
  booth_state_t w_next;

  logic [WIDTH:0]   r_a_ext;
  logic [WIDTH+2:0] r_b_ext;
  logic             r_pp_valid;
  logic [PP_PER_BEAT*DW-1:0] r_pp_data;
  logic [IW-1:0]    r_pp_index;
  logic             r_pp_last;

  logic             w_accept;
  logic             w_fire;
  logic [WIDTH:0]   w_a_in;
  logic [WIDTH+2:0] w_b_in;
  logic [WIDTH:0]   w_a_src;
  logic [WIDTH+2:0] w_b_src;
  logic [IW-1:0]    w_sel;
  logic [PP_PER_BEAT*DW-1:0] w_beat;

  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_pp_valid && pp_ready;

  assign w_a_in = {in_signed & in_a[WIDTH-1], in_a};
  assign w_b_in = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};

  // Beat 0 is built straight from the inputs so it can be
  // registered on the accepting edge (latency 1)
  assign w_a_src = (r_state == S_IDLE) ? w_a_in : r_a_ext;
  assign w_b_src = (r_state == S_IDLE) ? w_b_in : r_b_ext;
  assign w_sel   = (r_state == S_IDLE)
    ? '0
    : r_pp_index + IW'(1);

  for (genvar k = 0; k < PP_PER_BEAT; k++) begin : g_slot
    logic [GW-1:0] w_grp;
    logic [2:0]    w_bits;
    logic [DW-1:0] w_pp;

    assign w_grp = GW'(w_sel) * GW'(PP_PER_BEAT) + GW'(k);
    assign w_bits = 3'(w_b_src >> {w_grp, 1'b0});

    booth_pp_slice #(
      .WIDTH (WIDTH),
      .GW    (GW)
    ) u_slice (
      .i_a_ext (w_a_src),
      .i_bits  (w_bits),
      .i_grp   (w_grp),
      .o_pp    (w_pp)
    );

    assign w_beat[k*DW +: DW] =
      (w_grp < GW'(NUM_PP)) ? w_pp : '0;
  end

  // State register
  always_ff @(posedge mul_clk) begin
    if (mul_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: one transaction at a time, back to IDLE on last beat
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_GEN;
      S_GEN:  if (w_fire && r_pp_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Input handshake: only idle and out of reset
  always_comb begin
    in_ready = (r_state == S_IDLE) && !mul_rst;
  end

  // Operand capture on accept; held for the whole transaction
  always_ff @(posedge mul_clk) begin
    if (mul_rst) begin
      r_a_ext <= '0;
      r_b_ext <= '0;
    end else if (w_accept) begin
      r_a_ext <= w_a_in;
      r_b_ext <= w_b_in;
    end
  end

  // Output beat register; holds whenever no handshake occurs
  always_ff @(posedge mul_clk) begin
    if (mul_rst) begin
      r_pp_valid <= 1'b0;
      r_pp_data  <= '0;
      r_pp_index <= '0;
      r_pp_last  <= 1'b0;
    end else if (w_accept) begin
      r_pp_valid <= 1'b1;
      r_pp_data  <= w_beat;
      r_pp_index <= '0;
      r_pp_last  <= (NUM_BEATS == 1);
    end else if (w_fire) begin
      if (r_pp_last) begin
        r_pp_valid <= 1'b0;
      end else begin
        r_pp_data  <= w_beat;
        r_pp_index <= w_sel;
        r_pp_last  <= (w_sel == LB);
      end
    end
  end

  assign pp_valid = r_pp_valid;
  assign pp_data  = r_pp_data;
  assign pp_index = r_pp_index;
  assign pp_last  = r_pp_last;

endmodule

// File: tb/tb_booth_pp_stream.sv
// tb_booth_pp_stream: directed vectors for the Booth partial-product
// streamer, PP_PER_BEAT=1 and PP_PER_BEAT=4 instances.
module tb_booth_pp_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v1, rdy1, s1, pv1, pr1, pl1;
  logic [31:0] a1, b1;
  logic [63:0] pd1;
  logic [4:0]  pi1;

  logic        v2, rdy2, s2, pv2, pr2, pl2;
  logic [31:0] a2, b2;
  logic [255:0] pd2;
  logic [2:0]  pi2;

  booth_pp_stream #(.WIDTH(32), .PP_PER_BEAT(1)) u_dut1 (
    .mul_clk   (clk),
    .mul_rst   (rst),
    .in_valid  (v1),
    .in_ready  (rdy1),
    .in_a      (a1),
    .in_b      (b1),
    .in_signed (s1),
    .pp_valid  (pv1),
    .pp_ready  (pr1),
    .pp_data   (pd1),
    .pp_index  (pi1),
    .pp_last   (pl1)
  );

  booth_pp_stream #(.WIDTH(32), .PP_PER_BEAT(4)) u_dut4 (
    .mul_clk   (clk),
    .mul_rst   (rst),
    .in_valid  (v2),
    .in_ready  (rdy2),
    .in_a      (a2),
    .in_b      (b2),
    .in_signed (s2),
    .pp_valid  (pv2),
    .pp_ready  (pr2),
    .pp_data   (pd2),
    .pp_index  (pi2),
    .pp_last   (pl2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] sum;
    int          pidx;
    logic [63:0] pval;
  } vec_t;

  vec_t tbl[7];

  task automatic run1(input logic sgn,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [63:0] exp_sum,
                      input int pidx,
                      input logic [63:0] pval,
                      input int stall_at);
    logic [63:0] sum;
    logic [63:0] held;
    int beats;
    int stalls;
    int cyc;
    logic done;
    sum = '0; held = '0;
    beats = 0; stalls = 0; cyc = 0; done = 1'b0;
    @(negedge clk);
    chk("in_ready idle", 64'(rdy1), 64'd1);
    v1 = 1'b1; s1 = sgn; a1 = a; b1 = b; pr1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    while (!done && cyc < 100) begin
      cyc++;
      if (pv1) begin
        chk("in_ready gen", 64'(rdy1), 64'd0);
        if (int'(pi1) == stall_at && stalls < 5) begin
          if (stalls == 0) begin
            held = pd1;
          end else begin
            chk("stall data", pd1, held);
            chk("stall index", 64'(pi1), 64'(stall_at));
          end
          pr1 = 1'b0;
          stalls++;
        end else begin
          pr1 = 1'b1;
          chk("index", 64'(pi1), 64'(beats));
          chk("last", 64'(pl1), 64'(beats == 16));
          if (beats == pidx) chk("pp value", pd1, pval);
          sum += pd1;
          beats++;
          if (pl1) done = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (stall_at >= 0) chk("stall count", 64'(stalls), 64'd5);
    chk("beats", 64'(beats), 64'd17);
    chk("sum", sum, exp_sum);
    chk("valid drop", 64'(pv1), 64'd0);
    chk("in_ready back", 64'(rdy1), 64'd1);
  endtask

  initial begin
    int cyc;
    int beats;
    logic [63:0] sum;
    logic done;

    tbl[0] = '{1'b0, 32'd3, 32'd5, 64'd15, 1, 64'd12};
    tbl[1] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF,
               64'd7, 0, 64'd7};
    tbl[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               64'hFFFFFFFE00000001, 16, 64'hFFFFFFFF00000000};
    tbl[3] = '{1'b1, 32'd5, 32'hFFFFFFFD,
               64'hFFFFFFFFFFFFFFF1, 1, 64'hFFFFFFFFFFFFFFEC};
    tbl[4] = '{1'b1, 32'h80000000, 32'h7FFFFFFF,
               64'hC000000080000000, 16, 64'd0};
    tbl[5] = '{1'b0, 32'h80000000, 32'd2,
               64'h0000000100000000, 0, 64'hFFFFFFFF00000000};
    tbl[6] = '{1'b1, 32'h80000000, 32'h80000000,
               64'h4000000000000000, 15, 64'h4000000000000000};

    rst = 1'b1;
    v1 = 0; s1 = 0; a1 = 0; b1 = 0; pr1 = 1;
    v2 = 0; s2 = 0; a2 = 0; b2 = 0; pr2 = 1;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 64'(rdy1), 64'd0);
    chk("rst pp_valid", 64'(pv1), 64'd0);
    chk("rst pp_data", pd1, 64'd0);
    chk("rst pp_index", 64'(pi1), 64'd0);
    chk("rst pp_last", 64'(pl1), 64'd0);
    chk("rst pp_valid4", 64'(pv2), 64'd0);
    chk("rst in_ready4", 64'(rdy2), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run1(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].sum,
           tbl[i].pidx, tbl[i].pval, -1);
    end

    run1(1'b0, 32'd3, 32'd5, 64'd15, 3, 64'd0, 3);

    @(negedge clk);
    v1 = 1'b1; s1 = 1'b0; a1 = 32'd3; b1 = 32'd5; pr1 = 1'b1;
    @(negedge clk);
    a1 = 32'hFFFFFFFF; b1 = 32'hFFFFFFFF;
    cyc = 0;
    while (!(pv1 && pi1 == 5'd8) && cyc < 40) begin
      cyc++;
      chk("in_ready gen hold", 64'(rdy1), 64'd0);
      if (pv1 && pi1 == 5'd1) chk("no resample", pd1, 64'd12);
      @(negedge clk);
    end
    chk("reach beat 8", 64'(pi1), 64'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst pp_valid", 64'(pv1), 64'd0);
    chk("midrst pp_index", 64'(pi1), 64'd0);
    chk("midrst pp_data", pd1, 64'd0);
    chk("midrst in_ready", 64'(rdy1), 64'd0);
    rst = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    chk("postrst pp_valid", 64'(pv1), 64'd0);
    chk("postrst in_ready", 64'(rdy1), 64'd1);
    run1(1'b0, 32'd3, 32'd5, 64'd15, 0, 64'd3, -1);

    @(negedge clk);
    v2 = 1'b1; s2 = 1'b1;
    a2 = 32'h80000000; b2 = 32'h80000000; pr2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    cyc = 0; beats = 0; sum = '0; done = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      if (pv2) begin
        chk("ppb4 index", 64'(pi2), 64'(beats));
        chk("ppb4 last", 64'(pl2), 64'(beats == 4));
        for (int k = 0; k < 4; k++) sum += pd2[k*64 +: 64];
        if (beats == 4) begin
          for (int k = 0; k < 4; k++)
            chk("ppb4 tail slot", pd2[k*64 +: 64], 64'd0);
        end
        if (beats == 3)
          chk("ppb4 pp15", pd2[192 +: 64], 64'h4000000000000000);
        beats++;
        if (pl2) done = 1'b1;
      end
      @(negedge clk);
    end
    chk("ppb4 beats", 64'(beats), 64'd5);
    chk("ppb4 sum", sum, 64'h4000000000000000);
    chk("ppb4 valid drop", 64'(pv2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
